dmem_req_ctrl: RTL and testbench

- Data-memory request controller between the core's execute stage and the data memory.
- Converts LW/LBU/SW/SB requests into the mem_in_s/mem_out_s handshake.
- Stalls the core until the access completes, then returns load data already byte-extracted.
- Tracks progress with the shared dmem_req_state enum (DMEM_IDLE, DMEM_REQ_SENT, DMEM_REQ_ACKED).

---
 rtl/dmem_req_ctrl_pkg.sv | 30 +++
 rtl/dmem_req_ctrl_if.sv | 19 +
 rtl/dmem_byte_fmt.sv | 29 ++
 rtl/dmem_req_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_req_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_req_ctrl_pkg.sv
// Shared types for the data-memory request path.
//   mem_in_s        : controller -> memory request packet
//   mem_out_s       : memory -> controller response packet
//   dmem_req_state  : controller progress (idle / request sent / request acked)
package dmem_req_ctrl_pkg;

    localparam int data_mem_addr_width_gp = 32;
    localparam int byte_lanes_gp          = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE      = 2'd0,
        DMEM_REQ_SENT  = 2'd1,
        DMEM_REQ_ACKED = 2'd2
    } dmem_req_state;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic [31:0] write_data;
        logic        yumi;          // consumes a read response
    } mem_in_s;

    typedef struct packed {
        logic        valid;         // read_data is valid
        logic        yumi;          // request accepted
        logic [31:0] read_data;
    } mem_out_s;

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// Memory-side bus of the data-memory request controller.
//   to_mem_o   : request packet (controller drives)
//   mem_addr_o : registered request address (controller drives)
//   from_mem_i : response packet (memory drives)
// master = controller, slave = memory.
interface dmem_req_ctrl_if
    import dmem_req_ctrl_pkg::*;
#(
    parameter int addr_width_p = data_mem_addr_width_gp
) ();

    mem_in_s                 to_mem_o;
    logic [addr_width_p-1:0] mem_addr_o;
    mem_out_s                from_mem_i;

    modport master (output to_mem_o, output mem_addr_o, input from_mem_i);
    modport slave  (input to_mem_o, input mem_addr_o, output from_mem_i);

endinterface

// File: rtl/dmem_byte_fmt.sv
// Byte-lane formatter, purely combinational.
//   isRead=0 (store path): byte op replicates the selected byte into all lanes.
//   isRead=1 (load path) : byte op zero-extends the selected lane.
//   Word ops pass dataIn through unchanged.
// Ports: isByte, laneSel (byte lane, little endian), dataIn, dataOut.
module dmem_byte_fmt
    import dmem_req_ctrl_pkg::*;
#(
    parameter bit isRead = 1'b0
) (
    input  logic        isByte,
    input  logic [1:0]  laneSel,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut
);

    logic [7:0] laneByte;

    assign laneByte = dataIn[{laneSel, 3'b000} +: 8];

    generate
        if (isRead) begin : gRead
            assign dataOut = isByte ? {24'b0, laneByte} : dataIn;
        end else begin : gWrite
            assign dataOut = isByte ? {byte_lanes_gp{laneByte}} : dataIn;
        end
    endgenerate

endmodule

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller between execute stage and data memory.
// Turns LW/LBU/SW/SB into the mem_in_s/mem_out_s handshake, stalls the core
// until the access completes and returns byte-extracted load data.
// Ports:
//   clk, n_reset (sync, active low)
//   req_valid_i/req_wen_i/req_byte_i/req_addr_i/req_wdata_i : core request
//   stall_o, done_o, rdata_o : core response
//   err_o : watchdog error
//   mem (dmem_req_ctrl_if.master) : to_mem_o, mem_addr_o, from_mem_i
// Optional: DMEM_REQ_CTRL_TIMEOUT_EN adds a watchdog of timeout_cycles_p
// non-idle cycles; without it err_o is tied low.
module dmem_req_ctrl
    import dmem_req_ctrl_pkg::*;
#(
    parameter int addr_width_p     = data_mem_addr_width_gp,
    parameter int timeout_cycles_p = 256
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    req_valid_i,
    input  logic                    req_wen_i,
    input  logic                    req_byte_i,
    input  logic [addr_width_p-1:0] req_addr_i,
    input  logic [31:0]             req_wdata_i,
    output logic                    stall_o,
    output logic [31:0]             rdata_o,
    output logic                    done_o,
    output logic                    err_o,
    dmem_req_ctrl_if.master         mem
);

    dmem_req_state           state, stateNext;
    logic                    reqWen, reqByte;
    logic [addr_width_p-1:0] reqAddr;
    logic [31:0]             reqWdata, wdataFmt;
    logic                    toMemValid, toMemYumi;
    logic                    accept, errHold, timeoutHit;

    dmem_byte_fmt #(.isRead(1'b0)) wrFmt (
        .isByte (req_byte_i),
        .laneSel(2'b00),
        .dataIn (req_wdata_i),
        .dataOut(wdataFmt)
    );

    dmem_byte_fmt #(.isRead(1'b1)) rdFmt (
        .isByte (reqByte),
        .laneSel(reqAddr[1:0]),
        .dataIn (mem.from_mem_i.read_data),
        .dataOut(rdata_o)
    );

    // A timed-out controller refuses new work until reset.
    assign accept  = (state == DMEM_IDLE) && req_valid_i && !errHold;
    assign stall_o = req_valid_i & ~done_o;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state    <= DMEM_IDLE;
            reqWen   <= 1'b0;
            reqByte  <= 1'b0;
            reqAddr  <= '0;
            reqWdata <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                reqWen   <= req_wen_i;
                reqByte  <= req_byte_i;
                reqAddr  <= req_addr_i;
                reqWdata <= wdataFmt;
            end
        end
    end

    always_comb begin
        stateNext  = state;
        done_o     = 1'b0;
        toMemValid = 1'b0;
        toMemYumi  = 1'b0;
        case (state)
            DMEM_IDLE: begin
                if (accept) stateNext = DMEM_REQ_SENT;
            end
            DMEM_REQ_SENT: begin
                toMemValid = 1'b1;
                if (mem.from_mem_i.yumi) begin
                    if (reqWen) begin
                        done_o    = 1'b1;
                        stateNext = DMEM_IDLE;
                    end else if (mem.from_mem_i.valid) begin
                        // Data came back with the accept: consume it now.
                        done_o    = 1'b1;
                        toMemYumi = 1'b1;
                        stateNext = DMEM_IDLE;
                    end else begin
                        stateNext = DMEM_REQ_ACKED;
                    end
                end
            end
            DMEM_REQ_ACKED: begin
                if (mem.from_mem_i.valid) begin
                    done_o    = 1'b1;
                    toMemYumi = 1'b1;
                    stateNext = DMEM_IDLE;
                end
            end
            default: stateNext = DMEM_IDLE;
        endcase
        // Completion in the deadline cycle wins over the watchdog.
        if (timeoutHit) stateNext = DMEM_IDLE;
    end

    always_comb begin
        mem.to_mem_o               = '0;
        mem.to_mem_o.valid         = toMemValid;
        mem.to_mem_o.wen           = reqWen;
        mem.to_mem_o.byte_not_word = reqByte;
        mem.to_mem_o.write_data    = reqWdata;
        mem.to_mem_o.yumi          = toMemYumi;
    end

    assign mem.mem_addr_o = reqAddr;

`ifdef DMEM_REQ_CTRL_TIMEOUT_EN
    localparam int CntW = $clog2(timeout_cycles_p + 1);

    logic [CntW-1:0] toCnt;
    logic            errReg;

    // toCnt counts non-idle cycles of the current access, starting at 0.
    assign timeoutHit = (state != DMEM_IDLE) && !done_o &&
                        (toCnt == CntW'(timeout_cycles_p - 1));
    assign errHold    = errReg;
    assign err_o      = errReg;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            toCnt  <= '0;
            errReg <= 1'b0;
        end else begin
            if (accept)                  toCnt <= '0;
            else if (state != DMEM_IDLE) toCnt <= toCnt + 1'b1;
            if (timeoutHit)              errReg <= 1'b1;
        end
    end
`else
    logic unusedTimeout;

    assign unusedTimeout = ^timeout_cycles_p;
    assign timeoutHit    = 1'b0;
    assign errHold       = 1'b0;
    assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_req_ctrl.sv
module tb_dmem_req_ctrl;
    import dmem_req_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        req_valid_i, req_wen_i, req_byte_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        stall_o, done_o, err_o;
    logic [31:0] rdata_o;

    int passCnt  = 0;
    int totalCnt = 0;

    dmem_req_ctrl_if #(.addr_width_p(32)) memIf ();

    dmem_req_ctrl #(.addr_width_p(32), .timeout_cycles_p(8)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .req_valid_i(req_valid_i),
        .req_wen_i  (req_wen_i),
        .req_byte_i (req_byte_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .stall_o    (stall_o),
        .rdata_o    (rdata_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .mem        (memIf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;     // memory read data
        int          yd;     // cycles of valid before yumi
        int          vd;     // cycles from yumi to read valid (loads)
        bit          spur;   // drive stray from_mem.valid during a store
        logic [31:0] expR;
        logic [31:0] expW;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: an access completes yd+1 cycles after issue (stores) or
    // vd more cycles later (loads); request is presented until yumi.
    task automatic runOp(input vec_t v, input string tag);
        int doneCyc;
        doneCyc = 1 + v.yd + (v.wen ? 0 : v.vd);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_wen_i   = v.wen;
        req_byte_i  = v.byt;
        req_addr_i  = v.addr;
        req_wdata_i = v.wdata;
        memIf.from_mem_i = '0;
        #1;
        check({tag, " issue stall"}, 64'(stall_o), 64'd1);
        check({tag, " issue valid"}, 64'(memIf.to_mem_o.valid), 64'd0);
        for (int k = 1; k <= doneCyc; k++) begin
            @(negedge clk);
            memIf.from_mem_i.yumi      = (k == 1 + v.yd);
            memIf.from_mem_i.valid     = v.wen ? v.spur : (k == doneCyc);
            memIf.from_mem_i.read_data = (k == doneCyc) ? v.rd : $urandom;
            #1;
            check({tag, " to_mem valid"}, 64'(memIf.to_mem_o.valid), 64'(k <= 1 + v.yd));
            if (k <= 1 + v.yd) begin
                check({tag, " wen"}, 64'(memIf.to_mem_o.wen), 64'(v.wen));
                check({tag, " byte"}, 64'(memIf.to_mem_o.byte_not_word), 64'(v.byt));
                check({tag, " wdata"}, 64'(memIf.to_mem_o.write_data), 64'(v.expW));
                check({tag, " addr"}, 64'(memIf.mem_addr_o), 64'(v.addr));
            end
            check({tag, " done"}, 64'(done_o), 64'(k == doneCyc));
            check({tag, " stall"}, 64'(stall_o), 64'(k != doneCyc));
            check({tag, " to_mem yumi"}, 64'(memIf.to_mem_o.yumi), 64'(!v.wen && k == doneCyc));
            if (k == doneCyc && !v.wen) check({tag, " rdata"}, 64'(rdata_o), 64'(v.expR));
        end
        // Bubble cycle: nothing in flight, stray valid must not be consumed.
        @(negedge clk);
        req_valid_i = 1'b0;
        memIf.from_mem_i.yumi  = 1'b0;
        memIf.from_mem_i.valid = v.spur;
        #1;
        check({tag, " bubble done"}, 64'(done_o), 64'd0);
        check({tag, " bubble valid"}, 64'(memIf.to_mem_o.valid), 64'd0);
        check({tag, " bubble yumi"}, 64'(memIf.to_mem_o.yumi), 64'd0);
        @(negedge clk);
        memIf.from_mem_i = '0;
    endtask

    initial begin
        vec_t rv;
        n_reset = 1'b0;
        req_valid_i = 1'b0; req_wen_i = 1'b0; req_byte_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0;
        memIf.from_mem_i = '0;

        //          wen   byt   addr    wdata         rd            yd vd spur expR          expW
        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0BADF00D, 32'hDEADBEEF, 0, 2, 0, 32'hDEADBEEF, 32'h0BADF00D};
        vecs[1] = '{1'b0, 1'b1, 32'h13, 32'h000000FF, 32'h11223344, 1, 1, 0, 32'h00000011, 32'hFFFFFFFF};
        vecs[2] = '{1'b0, 1'b1, 32'h10, 32'h00000000, 32'h11223344, 0, 0, 0, 32'h00000044, 32'h00000000};
        vecs[3] = '{1'b1, 1'b1, 32'h21, 32'h000000A5, 32'h0,        2, 0, 1, 32'h0,        32'hA5A5A5A5};
        vecs[4] = '{1'b1, 1'b0, 32'h22, 32'hCAFEBABE, 32'h0,        0, 0, 1, 32'h0,        32'hCAFEBABE};
        vecs[5] = '{1'b0, 1'b0, 32'h07, 32'h00000000, 32'h87654321, 0, 0, 0, 32'h87654321, 32'h00000000};
        vecs[6] = '{1'b0, 1'b1, 32'h12, 32'h123456A5, 32'hA1B2C3D4, 3, 4, 0, 32'h000000B2, 32'hA5A5A5A5};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset to_mem", 64'(memIf.to_mem_o), 64'd0);
        check("reset mem_addr", 64'(memIf.mem_addr_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        check("reset err", 64'(err_o), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i < 7; i++) runOp(vecs[i], $sformatf("vec%0d", i));

        // Randomized accesses against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            rv.wen   = 1'($urandom_range(0, 1));
            rv.byt   = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.rd    = $urandom;
            rv.yd    = int'($urandom_range(0, 3));
            rv.vd    = int'($urandom_range(0, 3));
            rv.spur  = rv.wen ? 1'($urandom_range(0, 1)) : 1'b0;
            rv.expR  = rv.byt ? ((rv.rd >> (8 * (rv.addr % 4))) & 32'hFF) : rv.rd;
            rv.expW  = rv.byt ? (rv.wdata % 256) * 32'h01010101 : rv.wdata;
            runOp(rv, $sformatf("rnd%0d", i));
        end

        // Reset while waiting for read data, then a late response
        @(negedge clk);
        req_valid_i = 1'b1; req_wen_i = 1'b0; req_byte_i = 1'b0;
        req_addr_i = 32'h40; req_wdata_i = 32'h5555AAAA;
        @(negedge clk);
        memIf.from_mem_i.yumi = 1'b1;
        @(negedge clk);
        memIf.from_mem_i.yumi = 1'b0;
        #1;
        check("acked valid low", 64'(memIf.to_mem_o.valid), 64'd0);
        check("acked stall", 64'(stall_o), 64'd1);
        n_reset = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        memIf.from_mem_i.valid = 1'b1;
        memIf.from_mem_i.read_data = 32'h12345678;
        #1;
        check("post-reset done", 64'(done_o), 64'd0);
        check("post-reset yumi", 64'(memIf.to_mem_o.yumi), 64'd0);
        check("post-reset to_mem", 64'(memIf.to_mem_o), 64'd0);
        check("post-reset mem_addr", 64'(memIf.mem_addr_o), 64'd0);
        @(negedge clk);
        memIf.from_mem_i = '0;
        runOp(vecs[0], "after-reset");

`ifdef DMEM_REQ_CTRL_TIMEOUT_EN
        // Watchdog: memory never accepts
        @(negedge clk);
        req_valid_i = 1'b1; req_wen_i = 1'b0; req_byte_i = 1'b0;
        req_addr_i = 32'h80;
        memIf.from_mem_i = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("wd valid c%0d", k), 64'(memIf.to_mem_o.valid), 64'd1);
            check($sformatf("wd err c%0d", k), 64'(err_o), 64'd0);
        end
        for (int k = 9; k <= 11; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("wd err c%0d", k), 64'(err_o), 64'd1);
            check($sformatf("wd valid c%0d", k), 64'(memIf.to_mem_o.valid), 64'd0);
            check($sformatf("wd done c%0d", k), 64'(done_o), 64'd0);
            check($sformatf("wd stall c%0d", k), 64'(stall_o), 64'd1);
        end
        @(negedge clk);
        n_reset = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        #1;
        check("wd err cleared", 64'(err_o), 64'd0);
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
